rk8je_databreak: RTL and testbench

- Data-break (DMA) engine downstream of the RK8JE register block.
- On a start pulse it moves one sector between a 256-word sector buffer and PDP-8/L memory through the break request/grant handshake.
  - Disk read: the ARM has already filled the buffer; words go buffer to memory.
  - Disk write: words go memory to buffer, then the ARM writes the buffer to the disk image.
- Reports final current address, completion and data-request-late error back to the controller register block.

---
 rtl/rk8je_databreak_if.sv | 32 +++
 rtl/rk8je_databreak.sv | 219 +++++++++++++++++++++
 tb/tb_rk8je_databreak.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rk8je_databreak_if.sv
// rk8je_databreak_if
// Groups the two buses driven by the RK8JE data-break engine:
//   - break bus to the PDP-8/L memory interface:
//     brkrqst/brkgrant handshake, brkaddr, brkwrite, brkwdata, brkrdata, brkdone
//   - sector buffer port:
//     bufaddr, bufrdata (one cycle after bufaddr), bufwdata, bufwena
// Modports:
//   master - the data-break engine.
//   slave  - memory interface plus sector buffer.
interface rk8je_databreak_if;
    logic        brkrqst;
    logic        brkgrant;
    logic [14:0] brkaddr;
    logic        brkwrite;
    logic [11:0] brkwdata;
    logic [11:0] brkrdata;
    logic        brkdone;
    logic [7:0]  bufaddr;
    logic [11:0] bufrdata;
    logic [11:0] bufwdata;
    logic        bufwena;

    modport master (
        output brkrqst, brkaddr, brkwrite, brkwdata, bufaddr, bufwdata, bufwena,
        input  brkgrant, brkrdata, brkdone, bufrdata
    );

    modport slave (
        input  brkrqst, brkaddr, brkwrite, brkwdata, bufaddr, bufwdata, bufwena,
        output brkgrant, brkrdata, brkdone, bufrdata
    );
endinterface

// File: rtl/rk8je_databreak.sv
// rk8je_databreak
// Moves one disk sector between the 256-word sector buffer and PDP-8/L memory
// using the break request/grant handshake.
//   Disk read  (dowrite=0): buffer -> memory.
//   Disk write (dowrite=1): memory -> buffer.
// Ports:
//   CLOCK, RESET          clock and synchronous active-high reset
//   start, abort          one-cycle control pulses
//   dowrite, halfblk,
//   field, startaddr      transfer setup, sampled on start
//   bus (master)          break bus and sector buffer port
//   busy, donepulse,
//   drlate                transfer status (drlate is sticky until next start)
//   curaddr, wordcnt      progress; both hold their final values when idle
module rk8je_databreak #(
    parameter int BRKTMO = 4095,
    parameter int HALFWC = 128,
    parameter int FULLWC = 256
) (
    input  logic                      CLOCK,
    input  logic                      RESET,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      dowrite,
    input  logic                      halfblk,
    input  logic [2:0]                field,
    input  logic [11:0]               startaddr,
    rk8je_databreak_if.master         bus,
    output logic                      busy,
    output logic                      donepulse,
    output logic                      drlate,
    output logic [11:0]               curaddr,
    output logic [8:0]                wordcnt
);
    localparam logic [11:0] TMO_MAX = 12'(BRKTMO);

    // LATCH is the second fetch cycle: the buffer answers one cycle after bufaddr.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_REQ   = 3'd3,
        S_WAIT  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  field_q, field_d;
    logic        dowrite_q, dowrite_d;
    logic        halfblk_q, halfblk_d;
    logic [11:0] curaddr_q, curaddr_d;
    logic [8:0]  wordcnt_q, wordcnt_d;
    logic [11:0] tmo_q, tmo_d;
    logic        busy_q, busy_d;
    logic        donepulse_q, donepulse_d;
    logic        drlate_q, drlate_d;
    logic        brkrqst_q, brkrqst_d;
    logic        brkwrite_q, brkwrite_d;
    logic [11:0] brkwdata_q, brkwdata_d;
    logic [7:0]  bufaddr_q, bufaddr_d;
    logic [11:0] bufwdata_q, bufwdata_d;
    logic        bufwena_q, bufwena_d;

    logic        start_go_s;
    logic        step_s;
    logic        tmo_hit_s;
    logic [8:0]  nxt_wc_s;
    logic [8:0]  target_s;
    logic        last_s;

    assign nxt_wc_s   = wordcnt_q + 9'd1;
    assign target_s   = halfblk_q ? 9'(HALFWC) : 9'(FULLWC);
    assign start_go_s = (state_q == S_IDLE) && start;
    // One word completes when memory finishes the granted cycle, unless aborted.
    assign step_s     = (state_q == S_WAIT) && !abort && bus.brkdone;
    assign last_s     = step_s && (nxt_wc_s == target_s);
    // A grant in the final timeout cycle still wins.
    assign tmo_hit_s  = (state_q == S_REQ) && !abort && !bus.brkgrant && (tmo_q == TMO_MAX);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            field_q     <= 3'd0;
            dowrite_q   <= 1'b0;
            halfblk_q   <= 1'b0;
            curaddr_q   <= 12'd0;
            wordcnt_q   <= 9'd0;
            tmo_q       <= 12'd0;
            busy_q      <= 1'b0;
            donepulse_q <= 1'b0;
            drlate_q    <= 1'b0;
            brkrqst_q   <= 1'b0;
            brkwrite_q  <= 1'b0;
            brkwdata_q  <= 12'd0;
            bufaddr_q   <= 8'd0;
            bufwdata_q  <= 12'd0;
            bufwena_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            field_q     <= field_d;
            dowrite_q   <= dowrite_d;
            halfblk_q   <= halfblk_d;
            curaddr_q   <= curaddr_d;
            wordcnt_q   <= wordcnt_d;
            tmo_q       <= tmo_d;
            busy_q      <= busy_d;
            donepulse_q <= donepulse_d;
            drlate_q    <= drlate_d;
            brkrqst_q   <= brkrqst_d;
            brkwrite_q  <= brkwrite_d;
            brkwdata_q  <= brkwdata_d;
            bufaddr_q   <= bufaddr_d;
            bufwdata_q  <= bufwdata_d;
            bufwena_q   <= bufwena_d;
        end
    end

    // Next-state logic; abort returns any active state to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = dowrite ? S_REQ : S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: state_d = abort ? S_IDLE : S_LATCH;
            S_LATCH: state_d = abort ? S_IDLE : S_REQ;
            S_REQ: begin
                if (abort || tmo_hit_s) begin
                    state_d = S_IDLE;
                end else if (bus.brkgrant) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (abort || last_s) begin
                    state_d = S_IDLE;
                end else if (step_s) begin
                    state_d = dowrite_q ? S_REQ : S_FETCH;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        field_d     = field_q;
        dowrite_d   = dowrite_q;
        halfblk_d   = halfblk_q;
        brkwrite_d  = brkwrite_q;
        curaddr_d   = curaddr_q;
        wordcnt_d   = wordcnt_q;
        drlate_d    = drlate_q;
        brkwdata_d  = brkwdata_q;
        bufaddr_d   = bufaddr_q;
        bufwdata_d  = bufwdata_q;
        bufwena_d   = 1'b0;

        if (start_go_s) begin
            field_d    = field;
            dowrite_d  = dowrite;
            halfblk_d  = halfblk;
            brkwrite_d = ~dowrite;
            curaddr_d  = startaddr;
            wordcnt_d  = 9'd0;
            drlate_d   = 1'b0;
        end else if (step_s) begin
            // 12-bit wrap keeps the address inside the latched field.
            curaddr_d  = curaddr_q + 12'd1;
            wordcnt_d  = nxt_wc_s;
        end else if (tmo_hit_s) begin
            drlate_d   = 1'b1;
        end else begin
            drlate_d   = drlate_q;
        end

        if (state_q == S_LATCH) begin
            brkwdata_d = bus.bufrdata;
        end else begin
            brkwdata_d = brkwdata_q;
        end

        if (state_d == S_FETCH) begin
            bufaddr_d = wordcnt_d[7:0];
        end else if (step_s && dowrite_q) begin
            bufaddr_d  = wordcnt_q[7:0];
            bufwdata_d = bus.brkrdata;
            bufwena_d  = 1'b1;
        end else begin
            bufaddr_d  = bufaddr_q;
        end

        tmo_d       = (state_q == S_REQ) ? (tmo_q + 12'd1) : 12'd0;
        busy_d      = (state_d != S_IDLE);
        brkrqst_d   = (state_d == S_REQ);
        donepulse_d = last_s;
    end

    assign bus.brkrqst  = brkrqst_q;
    assign bus.brkaddr  = {field_q, curaddr_q};
    assign bus.brkwrite = brkwrite_q;
    assign bus.brkwdata = brkwdata_q;
    assign bus.bufaddr  = bufaddr_q;
    assign bus.bufwdata = bufwdata_q;
    assign bus.bufwena  = bufwena_q;
    assign busy         = busy_q;
    assign donepulse    = donepulse_q;
    assign drlate       = drlate_q;
    assign curaddr      = curaddr_q;
    assign wordcnt      = wordcnt_q;
endmodule

// File: tb/tb_rk8je_databreak.sv
// Testbench for rk8je_databreak: a memory/buffer model answers the break bus,
// expected memory and buffer writes are queued when a transfer is started and
// checked as the DUT produces them.
module tb_rk8je_databreak;
    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        dowrite = 1'b0;
    logic        halfblk = 1'b0;
    logic [2:0]  field = 3'd0;
    logic [11:0] startaddr = 12'd0;
    logic        busy, donepulse, drlate;
    logic [11:0] curaddr;
    logic [8:0]  wordcnt;

    rk8je_databreak_if bus();

    rk8je_databreak dut (
        .CLOCK(CLOCK), .RESET(RESET), .start(start), .abort(abort),
        .dowrite(dowrite), .halfblk(halfblk), .field(field), .startaddr(startaddr),
        .bus(bus), .busy(busy), .donepulse(donepulse), .drlate(drlate),
        .curaddr(curaddr), .wordcnt(wordcnt)
    );

    always #5 CLOCK = ~CLOCK;

    int tests = 0;
    int fails = 0;
    logic [26:0] mem_q[$];   // {addr[14:0], data[11:0]}
    logic [19:0] buf_q[$];   // {bufaddr[7:0], data[11:0]}
    int n_memwr = 0, n_bufwr = 0, n_done = 0;
    int lat = 0;
    int withhold = -1;
    int phase = 0, cnt = 0, gcnt = 0, didx = 0;
    logic [7:0] addr_prev = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
        end
    endtask

    // Memory interface and sector buffer model, plus write monitors.
    initial begin
        logic [26:0] me;
        logic [19:0] be;
        bus.brkgrant = 1'b0;
        bus.brkdone  = 1'b0;
        bus.brkrdata = 12'd0;
        bus.bufrdata = 12'd0;
        forever begin
            @(negedge CLOCK);
            bus.brkgrant = 1'b0;
            bus.brkdone  = 1'b0;
            // buffer[i] = i, answered one cycle after the address
            bus.bufrdata = {4'd0, addr_prev};
            addr_prev    = bus.bufaddr;
            if (donepulse === 1'b1) n_done++;
            if (bus.bufwena === 1'b1) begin
                n_bufwr++;
                if (buf_q.size() == 0) begin
                    chk("buf_extra_write", 32'(buf_q.size()), 32'd1);
                end else begin
                    be = buf_q.pop_front();
                    chk("buf_addr", 32'(bus.bufaddr), 32'(be[19:12]));
                    chk("buf_data", 32'(bus.bufwdata), 32'(be[11:0]));
                end
            end
            if (phase == 0 && busy !== 1'b1) gcnt = 0;
            if (phase == 1) begin
                if (cnt == 0) begin
                    bus.brkdone  = 1'b1;
                    bus.brkrdata = 12'o7000 + 12'(didx);
                    phase = 0;
                end else begin
                    cnt--;
                end
            end else if (bus.brkrqst === 1'b1 && gcnt != withhold) begin
                bus.brkgrant = 1'b1;
                phase = 1;
                cnt   = lat;
                didx  = gcnt;
                gcnt++;
                if (bus.brkwrite === 1'b1) begin
                    n_memwr++;
                    if (mem_q.size() == 0) begin
                        chk("mem_extra_write", 32'(mem_q.size()), 32'd1);
                    end else begin
                        me = mem_q.pop_front();
                        chk("mem_addr", 32'(bus.brkaddr), 32'(me[26:12]));
                        chk("mem_data", 32'(bus.brkwdata), 32'(me[11:0]));
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic dw, input logic hb, input logic [2:0] f,
                            input logic [11:0] sa, input logic ab);
        start = 1'b1; abort = ab; dowrite = dw; halfblk = hb; field = f; startaddr = sa;
        @(negedge CLOCK);
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int n = 0;
        while (busy === 1'b1 && n < maxc) begin
            @(negedge CLOCK);
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
        @(negedge CLOCK);
    endtask

    // Returns in the WAIT cycle of word w (its grant just consumed).
    task automatic wait_wc(input int w, input string tag);
        int n = 0;
        while (!(wordcnt == 9'(w) && bus.brkrqst === 1'b1) && n < 2000) begin
            @(negedge CLOCK);
            n++;
        end
        while (bus.brkrqst === 1'b1 && n < 2000) begin
            @(negedge CLOCK);
            n++;
        end
        chk(tag, 32'(n < 2000), 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".ctl"}, 32'({busy, donepulse, drlate, bus.brkrqst, bus.brkwrite, bus.bufwena}), 32'd0);
        chk({tag, ".addr"}, 32'({bus.brkaddr, bus.bufaddr}), 32'd0);
        chk({tag, ".data"}, 32'({bus.brkwdata, bus.bufwdata}), 32'd0);
        chk({tag, ".cnt"}, 32'({curaddr, wordcnt}), 32'd0);
    endtask

    initial begin
        int m0, b0, d0, rq, n;

        // Reset state
        RESET = 1'b1;
        repeat (3) @(negedge CLOCK);
        chk_zero("reset");
        RESET = 1'b0;
        @(negedge CLOCK);

        // Read, full block, field 2, start 0100, immediate grants
        lat = 0;
        for (int i = 0; i < 256; i++) mem_q.push_back({3'd2, 12'o0100 + 12'(i), 12'(i)});
        m0 = n_memwr; d0 = n_done;
        do_start(1'b0, 1'b0, 3'd2, 12'o0100, 1'b0);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_idle("t1_idle", 3000);
        chk("t1_curaddr", 32'(curaddr), 32'o0500);
        chk("t1_wordcnt", 32'(wordcnt), 32'd256);
        chk("t1_done", 32'(n_done - d0), 32'd1);
        chk("t1_memwr", 32'(n_memwr - m0), 32'd256);
        chk("t1_queue", 32'(mem_q.size()), 32'd0);
        chk("t1_drlate", 32'(drlate), 32'd0);

        // Write, half block, start 0200, memory returns 7000+i
        lat = 1;
        for (int i = 0; i < 128; i++) buf_q.push_back({8'(i), 12'o7000 + 12'(i)});
        m0 = n_memwr; b0 = n_bufwr; d0 = n_done;
        do_start(1'b1, 1'b1, 3'd0, 12'o0200, 1'b0);
        wait_idle("t2_idle", 3000);
        chk("t2_curaddr", 32'(curaddr), 32'o0400);
        chk("t2_wordcnt", 32'(wordcnt), 32'd128);
        chk("t2_bufwr", 32'(n_bufwr - b0), 32'd128);
        chk("t2_memwr", 32'(n_memwr - m0), 32'd0);
        chk("t2_done", 32'(n_done - d0), 32'd1);
        chk("t2_queue", 32'(buf_q.size()), 32'd0);

        // Address wrap inside field 5
        lat = 0;
        for (int i = 0; i < 256; i++) mem_q.push_back({3'd5, 12'o7776 + 12'(i), 12'(i)});
        do_start(1'b0, 1'b0, 3'd5, 12'o7776, 1'b0);
        wait_idle("t3_idle", 3000);
        chk("t3_curaddr", 32'(curaddr), 32'o0376);
        chk("t3_wordcnt", 32'(wordcnt), 32'd256);
        chk("t3_queue", 32'(mem_q.size()), 32'd0);

        // Timeout on the third word
        withhold = 2;
        for (int i = 0; i < 2; i++) mem_q.push_back({3'd0, 12'(i), 12'(i)});
        d0 = n_done;
        do_start(1'b0, 1'b0, 3'd0, 12'o0000, 1'b0);
        n = 0;
        while (!(wordcnt == 9'd2 && bus.brkrqst === 1'b1) && n < 200) begin
            @(negedge CLOCK);
            n++;
        end
        rq = 0;
        while (bus.brkrqst === 1'b1 && rq < 6000) begin
            @(negedge CLOCK);
            rq++;
        end
        chk("t4_tmo_len", 32'(rq >= 4095 && rq <= 4096), 32'd1);
        wait_idle("t4_idle", 10);
        chk("t4_drlate", 32'(drlate), 32'd1);
        chk("t4_wordcnt", 32'(wordcnt), 32'd2);
        chk("t4_done", 32'(n_done - d0), 32'd0);
        chk("t4_brkrqst", 32'(bus.brkrqst), 32'd0);
        chk("t4_queue", 32'(mem_q.size()), 32'd0);
        withhold = -1;
        for (int i = 0; i < 128; i++) buf_q.push_back({8'(i), 12'o7000 + 12'(i)});
        do_start(1'b1, 1'b1, 3'd0, 12'o0000, 1'b0);
        chk("t4_drlate_clr", 32'(drlate), 32'd0);
        wait_idle("t4_idle2", 3000);
        chk("t4_queue2", 32'(buf_q.size()), 32'd0);

        // Abort in WAIT of word 10; late brkdone must be ignored
        lat = 3;
        for (int i = 0; i < 10; i++) buf_q.push_back({8'(i), 12'o7000 + 12'(i)});
        b0 = n_bufwr; d0 = n_done;
        do_start(1'b1, 1'b0, 3'd0, 12'o0000, 1'b0);
        wait_wc(10, "t5_sync");
        abort = 1'b1;
        @(negedge CLOCK);
        abort = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_brkrqst", 32'(bus.brkrqst), 32'd0);
        chk("t5_wordcnt", 32'(wordcnt), 32'd10);
        chk("t5_curaddr", 32'(curaddr), 32'd10);
        repeat (10) @(negedge CLOCK);
        chk("t5_wordcnt_late", 32'(wordcnt), 32'd10);
        chk("t5_curaddr_late", 32'(curaddr), 32'd10);
        chk("t5_bufwr", 32'(n_bufwr - b0), 32'd10);
        chk("t5_done", 32'(n_done - d0), 32'd0);
        chk("t5_drlate", 32'(drlate), 32'd0);
        chk("t5_queue", 32'(buf_q.size()), 32'd0);

        // Reset in WAIT of word 3
        for (int i = 0; i < 4; i++) mem_q.push_back({3'd3, 12'(i), 12'(i)});
        do_start(1'b0, 1'b0, 3'd3, 12'o0000, 1'b0);
        wait_wc(3, "t6_sync");
        RESET = 1'b1;
        @(negedge CLOCK);
        chk_zero("t6_rst");
        RESET = 1'b0;
        repeat (10) @(negedge CLOCK);
        chk("t6_wordcnt_late", 32'(wordcnt), 32'd0);
        chk("t6_queue", 32'(mem_q.size()), 32'd0);

        // Start with abort in IDLE (start wins), then start while busy is ignored
        lat = 0;
        for (int i = 0; i < 128; i++) mem_q.push_back({3'd1, 12'o0100 + 12'(i), 12'(i)});
        d0 = n_done;
        do_start(1'b0, 1'b1, 3'd1, 12'o0100, 1'b1);
        chk("t7_busy", 32'(busy), 32'd1);
        repeat (20) @(negedge CLOCK);
        do_start(1'b1, 1'b0, 3'd4, 12'o0200, 1'b0);
        wait_idle("t7_idle", 3000);
        chk("t7_curaddr", 32'(curaddr), 32'o0300);
        chk("t7_wordcnt", 32'(wordcnt), 32'd128);
        chk("t7_done", 32'(n_done - d0), 32'd1);
        chk("t7_queue", 32'(mem_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
